// File: rtl/edge_bbox_pkg.sv
// edge_bbox_pkg: shared types and constants
// for the edge bounding-box locator.
package edge_bbox_pkg;

  localparam int COORD_W = 11;
  localparam int COUNT_W = 20;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    PUBLISH
  } state_e;

  localparam coord_t COORD_MIN_INIT = 11'd2047;
  localparam coord_t COORD_MAX_INIT = 11'd0;

  typedef struct packed {
    coord_t xmin;
    coord_t xmax;
    coord_t ymin;
    coord_t ymax;
    count_t cnt;
  } acc_t;

  localparam acc_t ACC_CLEAR = '{
    COORD_MIN_INIT, COORD_MAX_INIT,
    COORD_MIN_INIT, COORD_MAX_INIT,
    '0
  };

  function automatic count_t sat_inc(count_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/edge_bbox_if.sv
// edge_bbox_if: video-in / box-out bundle.
// post_* video-out exists only with EDGE_BBOX_OVERLAY_EN.
interface edge_bbox_if;
  import edge_bbox_pkg::*;

  logic   per_frame_vsync;
  logic   per_frame_href;
  logic   per_frame_clken;
  logic   per_img_Bit;
  logic   box_valid;
  logic   box_found;
  coord_t box_x_min;
  coord_t box_x_max;
  coord_t box_y_min;
  coord_t box_y_max;
  count_t edge_count;
`ifdef EDGE_BBOX_OVERLAY_EN
  logic   post_frame_vsync;
  logic   post_frame_href;
  logic   post_frame_clken;
  logic   post_img_Bit;
`endif

  modport master (
    output per_frame_vsync, per_frame_href,
    output per_frame_clken, per_img_Bit,
`ifdef EDGE_BBOX_OVERLAY_EN
    input  post_frame_vsync, post_frame_href,
    input  post_frame_clken, post_img_Bit,
`endif
    input  box_valid, box_found,
    input  box_x_min, box_x_max,
    input  box_y_min, box_y_max,
    input  edge_count
  );

  modport slave (
    input  per_frame_vsync, per_frame_href,
    input  per_frame_clken, per_img_Bit,
`ifdef EDGE_BBOX_OVERLAY_EN
    output post_frame_vsync, post_frame_href,
    output post_frame_clken, post_img_Bit,
`endif
    output box_valid, box_found,
    output box_x_min, box_x_max,
    output box_y_min, box_y_max,
    output edge_count
  );

endinterface

// File: rtl/edge_bbox_pos_counter.sv
// edge_bbox_pos_counter: column/row position of
// the current pixel, cleared per frame.
module edge_bbox_pos_counter
  import edge_bbox_pkg::*;
#(
  parameter int IMG_H = 640,
  parameter int IMG_V = 480
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear_i,
  input  logic   href_i,
  input  logic   clken_i,
  output coord_t x_o,
  output coord_t y_o,
  output logic   in_range_o
);

  localparam coord_t XLIM = COORD_W'(IMG_H);
  localparam coord_t YLIM = COORD_W'(IMG_V);

  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   href_q;
  logic   href_fall;

  assign href_fall = href_q & ~href_i;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (href_fall) begin
      x_d = '0;
      if (y_q != YLIM) y_d = y_q + 1'b1;
    end else if (href_i && clken_i) begin
      if (x_q != XLIM) x_d = x_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      href_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      href_q <= href_i;
    end
  end

  assign x_o        = x_q;
  assign y_o        = y_q;
  assign in_range_o = (x_q < XLIM) && (y_q < YLIM);

endmodule

// File: rtl/edge_bbox_locator.sv
// edge_bbox_locator: per-frame bounding box of edge pixels.
// Video overlay of the last box with EDGE_BBOX_OVERLAY_EN.
module edge_bbox_locator
  import edge_bbox_pkg::*;
#(
  parameter int IMG_H           = 640,
  parameter int IMG_V           = 480,
  parameter int MIN_EDGE_PIXELS = 16
) (
  input logic        clk,
  input logic        rst,
  edge_bbox_if.slave bus
);

  state_e state_q, state_d;
  logic   vs_q, rise, fall, clr;
  logic   accept, in_rng;
  coord_t px, py;
  logic   pix_vld_q;
  coord_t pix_x_q, pix_y_q;
  acc_t   acc_q, acc_d;
  acc_t   box_q, box_d;
  logic   found_q, found_d;
  logic   valid_q;

  assign rise   = bus.per_frame_vsync & ~vs_q;
  assign fall   = ~bus.per_frame_vsync & vs_q;
  assign accept = bus.per_frame_href & bus.per_frame_clken;

  edge_bbox_pos_counter #(
    .IMG_H(IMG_H),
    .IMG_V(IMG_V)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clr),
    .href_i    (bus.per_frame_href),
    .clken_i   (bus.per_frame_clken),
    .x_o       (px),
    .y_o       (py),
    .in_range_o(in_rng)
  );

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: if (rise) begin
        clr     = 1'b1;
        state_d = ACTIVE;
      end
      ACTIVE:  if (fall) state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge pixels are registered first; the compare happens a cycle later.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = ACC_CLEAR;
    end else if (pix_vld_q) begin
      if (pix_x_q < acc_q.xmin) acc_d.xmin = pix_x_q;
      if (pix_x_q > acc_q.xmax) acc_d.xmax = pix_x_q;
      if (pix_y_q < acc_q.ymin) acc_d.ymin = pix_y_q;
      if (pix_y_q > acc_q.ymax) acc_d.ymax = pix_y_q;
      acc_d.cnt = sat_inc(acc_q.cnt);
    end
  end

  always_comb begin
    found_d   = acc_q.cnt >= COUNT_W'(MIN_EDGE_PIXELS);
    box_d     = '0;
    box_d.cnt = acc_q.cnt;
    if (found_d) box_d = acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vs_q      <= 1'b0;
      acc_q     <= ACC_CLEAR;
      pix_vld_q <= 1'b0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      valid_q   <= 1'b0;
      found_q   <= 1'b0;
      box_q     <= '0;
    end else begin
      state_q   <= state_d;
      vs_q      <= bus.per_frame_vsync;
      acc_q     <= acc_d;
      pix_vld_q <= (state_q == ACTIVE) && accept &&
                   in_rng && !bus.per_img_Bit;
      pix_x_q   <= px;
      pix_y_q   <= py;
      valid_q   <= (state_q == PUBLISH);
      if (state_q == PUBLISH) begin
        found_q <= found_d;
        box_q   <= box_d;
      end
    end
  end

  assign bus.box_valid  = valid_q;
  assign bus.box_found  = found_q;
  assign bus.box_x_min  = box_q.xmin;
  assign bus.box_x_max  = box_q.xmax;
  assign bus.box_y_min  = box_q.ymin;
  assign bus.box_y_max  = box_q.ymax;
  assign bus.edge_count = box_q.cnt;

`ifdef EDGE_BBOX_OVERLAY_EN
  coord_t ox, oy;
  logic   orng, on_col, on_row, hit;
  logic [3:0] post_q;

  edge_bbox_pos_counter #(
    .IMG_H(IMG_H),
    .IMG_V(IMG_V)
  ) u_ov_pos (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (rise),
    .href_i    (bus.per_frame_href),
    .clken_i   (bus.per_frame_clken),
    .x_o       (ox),
    .y_o       (oy),
    .in_range_o(orng)
  );

  always_comb begin
    on_col = (ox == box_q.xmin || ox == box_q.xmax) &&
             oy >= box_q.ymin && oy <= box_q.ymax;
    on_row = (oy == box_q.ymin || oy == box_q.ymax) &&
             ox >= box_q.xmin && ox <= box_q.xmax;
    hit    = found_q && accept && orng && (on_col || on_row);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) post_q <= '0;
    else post_q <= {bus.per_frame_vsync, bus.per_frame_href,
                    bus.per_frame_clken, bus.per_img_Bit & ~hit};
  end

  assign bus.post_frame_vsync = post_q[3];
  assign bus.post_frame_href  = post_q[2];
  assign bus.post_frame_clken = post_q[1];
  assign bus.post_img_Bit     = post_q[0];
`endif

endmodule
